// File: rtl/decode_opnd_stream.sv
`default_nettype none
// decode_opnd_stream: byte-serial ModR/M / SIB / displacement / immediate walker that emits one
// registered operand record per instruction. Define DECODE_OPND_IMM_EN to consume and capture immediates.
module decode_opnd_stream #(
  parameter int MAX_LEN   = 15,
  parameter int PRE_LEN_W = 4,
  parameter int IMM_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [3:0]           opnd_form,
  input  logic                 prefix_address_16bit,
  input  logic [1:0]           imm_size,
  input  logic [PRE_LEN_W-1:0] pre_len,
  input  logic                 byte_valid,
  output logic                 byte_ready,
  input  logic [7:0]           byte_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 has_modrm,
  output logic                 has_sib,
  output logic                 has_disp,
  output logic                 has_imm,
  output logic [2:0]           disp_size,
  output logic [7:0]           modrm,
  output logic [7:0]           sib,
  output logic [31:0]          disp,
  output logic [IMM_W-1:0]     imm,
  output logic [3:0]           length,
  output logic                 err_too_long
);

  localparam logic [3:0] OPND_ENC_NONE       = 4'd0;
  localparam logic [3:0] OPND_ENC_RM         = 4'd1;
  localparam logic [3:0] OPND_ENC_REG_RM     = 4'd2;
  localparam logic [3:0] OPND_ENC_RM_IMM     = 4'd3;
  localparam logic [3:0] OPND_ENC_REG_RM_IMM = 4'd4;
  localparam logic [3:0] OPND_ENC_RM_REG     = 4'd5;
  localparam logic [3:0] OPND_ENC_RM_CL      = 4'd6;
  localparam logic [3:0] OPND_ENC_DISP8      = 4'd7;
  localparam logic [3:0] OPND_ENC_DISP32     = 4'd8;
  localparam logic [3:0] OPND_ENC_IMM        = 4'd9;
  localparam logic [3:0] OPND_ENC_REG_IMM    = 4'd10;
  localparam logic [3:0] MAX_LEN_C           = 4'(MAX_LEN);

  typedef enum logic [2:0] {S_IDLE, S_MODRM, S_SIB, S_DISP, S_IMM, S_DONE} state_t;

  state_t     state, state_nxt;
  logic       addr16;
  logic [2:0] disp_idx;
  logic       active, at_limit, byte_fire, disp_last, sib_base_d32;
  logic       form_modrm, form_imm, imm_last, modrm_sib;
  logic [2:0] modrm_dsz, start_dsz;

  assign start_ready  = (state == S_IDLE);
  assign out_valid    = (state == S_DONE);
  assign active       = (state inside {S_MODRM, S_SIB, S_DISP, S_IMM});
  assign at_limit     = (length == MAX_LEN_C);
  assign byte_ready   = active && !at_limit;
  assign byte_fire    = byte_ready && byte_valid;
  assign disp_last    = ((disp_idx + 3'd1) == disp_size);
  assign sib_base_d32 = (modrm[7:6] == 2'b00) && (byte_data[2:0] == 3'd5);
  assign form_modrm   = (opnd_form inside {OPND_ENC_RM, OPND_ENC_REG_RM, OPND_ENC_RM_IMM,
                                           OPND_ENC_REG_RM_IMM, OPND_ENC_RM_REG, OPND_ENC_RM_CL});
  assign start_dsz    = (opnd_form == OPND_ENC_DISP8)  ? 3'd1 :
                        (opnd_form == OPND_ENC_DISP32) ? 3'd4 : 3'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    modrm_sib = 1'b0;
    modrm_dsz = 3'd0;
    // Displacement size implied by the ModR/M byte currently on the bus.
    if (byte_data[7:6] != 2'b11) begin
      if (addr16) begin
        if (byte_data[7:6] == 2'b01)                               modrm_dsz = 3'd1;
        else if (byte_data[7:6] == 2'b10 || byte_data[2:0] == 3'd6) modrm_dsz = 3'd2;
      end else begin
        modrm_sib = (byte_data[2:0] == 3'd4);
        if (byte_data[7:6] == 2'b01)                               modrm_dsz = 3'd1;
        else if (byte_data[7:6] == 2'b10 || byte_data[2:0] == 3'd5) modrm_dsz = 3'd4;
      end
    end
    case (state)
      S_IDLE: if (start_valid) begin
        if (form_modrm)            state_nxt = S_MODRM;
        else if (start_dsz != 3'd0) state_nxt = S_DISP;
        else if (form_imm)         state_nxt = S_IMM;
        else                       state_nxt = S_DONE;
      end
      S_MODRM: if (at_limit) state_nxt = S_DONE;
        else if (byte_valid) begin
          if (modrm_sib)              state_nxt = S_SIB;
          else if (modrm_dsz != 3'd0) state_nxt = S_DISP;
          else if (has_imm)           state_nxt = S_IMM;
          else                        state_nxt = S_DONE;
        end
      S_SIB: if (at_limit) state_nxt = S_DONE;
        else if (byte_valid) begin
          if (disp_size != 3'd0 || sib_base_d32) state_nxt = S_DISP;
          else if (has_imm)                      state_nxt = S_IMM;
          else                                   state_nxt = S_DONE;
        end
      S_DISP: if (at_limit) state_nxt = S_DONE;
        else if (byte_valid && disp_last) state_nxt = has_imm ? S_IMM : S_DONE;
      S_IMM: if (at_limit) state_nxt = S_DONE;
        else if (byte_valid && imm_last) state_nxt = S_DONE;
      S_DONE: if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr16       <= 1'b0;
      has_modrm    <= 1'b0;
      has_sib      <= 1'b0;
      has_disp     <= 1'b0;
      disp_size    <= 3'd0;
      modrm        <= 8'd0;
      sib          <= 8'd0;
      disp         <= 32'd0;
      disp_idx     <= 3'd0;
      length       <= 4'd0;
      err_too_long <= 1'b0;
    end else if (start_ready && start_valid) begin
      addr16       <= prefix_address_16bit;
      has_modrm    <= 1'b0;
      has_sib      <= 1'b0;
      has_disp     <= (start_dsz != 3'd0);
      disp_size    <= start_dsz;
      modrm        <= 8'd0;
      sib          <= 8'd0;
      disp         <= 32'd0;
      disp_idx     <= 3'd0;
      length       <= 4'(pre_len);
      err_too_long <= 1'b0;
    end else if (byte_fire) begin
      length <= length + 4'd1;
      case (state)
        S_MODRM: begin
          modrm     <= byte_data;
          has_modrm <= 1'b1;
          has_sib   <= modrm_sib;
          disp_size <= modrm_dsz;
          has_disp  <= (modrm_dsz != 3'd0);
        end
        S_SIB: begin
          sib     <= byte_data;
          has_sib <= 1'b1;
          if (sib_base_d32) begin
            disp_size <= 3'd4;
            has_disp  <= 1'b1;
          end
        end
        S_DISP: begin
          // Sign extension happens on the final byte, once its sign bit is known.
          if (disp_last) begin
            case (disp_size)
              3'd1:    disp <= {{24{byte_data[7]}}, byte_data};
              3'd2:    disp <= {{16{byte_data[7]}}, byte_data, disp[7:0]};
              default: disp <= {byte_data, disp[23:0]};
            endcase
          end else begin
            disp[{disp_idx[1:0], 3'b000} +: 8] <= byte_data;
          end
          disp_idx <= disp_idx + 3'd1;
        end
        default: ;
      endcase
    end else if (active && at_limit) begin
      err_too_long <= 1'b1;
    end
  end

`ifdef DECODE_OPND_IMM_EN
  logic [2:0] imm_idx, imm_len;

  assign form_imm = (opnd_form inside {OPND_ENC_RM_IMM, OPND_ENC_REG_RM_IMM,
                                       OPND_ENC_IMM, OPND_ENC_REG_IMM});
  assign imm_last = ((imm_idx + 3'd1) == imm_len);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      has_imm <= 1'b0;
      imm     <= '0;
      imm_idx <= 3'd0;
      imm_len <= 3'd0;
    end else if (start_ready && start_valid) begin
      has_imm <= form_imm;
      imm     <= '0;
      imm_idx <= 3'd0;
      imm_len <= (imm_size == 2'd0) ? 3'd1 : (imm_size == 2'd1) ? 3'd2 : 3'd4;
    end else if (state == S_IMM && byte_fire) begin
      imm[{imm_idx[1:0], 3'b000} +: 8] <= byte_data;
      imm_idx <= imm_idx + 3'd1;
    end
  end
`else
  logic unused_imm_size;

  assign form_imm        = 1'b0;
  assign imm_last        = 1'b1;
  assign has_imm         = 1'b0;
  assign imm             = '0;
  assign unused_imm_size = ^imm_size;
`endif

endmodule
`default_nettype wire

// File: tb/tb_decode_opnd_stream.sv
`default_nettype none
`timescale 1ns/1ps
// Directed self-checking bench for decode_opnd_stream (expectations follow DECODE_OPND_IMM_EN if defined).
module tb_decode_opnd_stream;

  localparam logic [3:0] ENC_RM         = 4'd1;
  localparam logic [3:0] ENC_REG_RM     = 4'd2;
  localparam logic [3:0] ENC_RM_IMM     = 4'd3;
  localparam logic [3:0] ENC_RM_REG     = 4'd5;
  localparam logic [3:0] ENC_DISP8      = 4'd7;
  localparam logic [3:0] ENC_DISP32     = 4'd8;
  localparam logic [3:0] ENC_REG_IMM    = 4'd10;
`ifdef DECODE_OPND_IMM_EN
  localparam bit IMM_EN = 1'b1;
`else
  localparam bit IMM_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_valid = 1'b0, start_ready;
  logic [3:0]  opnd_form = 4'd0;
  logic        prefix_address_16bit = 1'b0;
  logic [1:0]  imm_size = 2'd0;
  logic [3:0]  pre_len = 4'd0;
  logic        byte_valid = 1'b0, byte_ready;
  logic [7:0]  byte_data = 8'd0;
  logic        out_valid, out_ready = 1'b0;
  logic        has_modrm, has_sib, has_disp, has_imm;
  logic [2:0]  disp_size;
  logic [7:0]  modrm, sib;
  logic [31:0] disp;
  logic [31:0] imm;
  logic [3:0]  length;
  logic        err_too_long;

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  byte_q[$];
  time         start_t, out_t;
  logic        br_first;

  decode_opnd_stream #(.MAX_LEN(15), .PRE_LEN_W(4), .IMM_W(32)) dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready),
    .opnd_form(opnd_form), .prefix_address_16bit(prefix_address_16bit),
    .imm_size(imm_size), .pre_len(pre_len),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_data(byte_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .has_modrm(has_modrm), .has_sib(has_sib), .has_disp(has_disp), .has_imm(has_imm),
    .disp_size(disp_size), .modrm(modrm), .sib(sib), .disp(disp), .imm(imm),
    .length(length), .err_too_long(err_too_long)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_instr(input logic [3:0] f, input logic a16, input logic [1:0] isz,
                             input logic [3:0] pl);
    int g;
    g = 0;
    while (!start_ready && g < 20) begin @(posedge clk); #1; g++; end
    chk("start_ready_before_start", start_ready, 1'b1);
    opnd_form = f; prefix_address_16bit = a16; imm_size = isz; pre_len = pl;
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    start_t  = $time;
    br_first = byte_ready;
  endtask

  task automatic feed(input int gap);
    int g;
    while (byte_q.size() > 0) begin
      g = 0;
      byte_data = byte_q[0];
      byte_valid = 1'b1;
      while (!byte_ready && !out_valid && g < 20) begin @(posedge clk); #1; g++; end
      if (!byte_ready) begin
        // Only a length-limit abort may stop the byte stream early.
        chk("byte_stream_ended_in_done", out_valid, 1'b1);
        byte_valid = 1'b0;
        byte_q.delete();
        break;
      end
      @(posedge clk); #1;
      void'(byte_q.pop_front());
      byte_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
    byte_valid = 1'b0;
  endtask

  task automatic wait_out;
    int g;
    g = 0;
    while (!out_valid && g < 40) begin @(posedge clk); #1; g++; end
    out_t = $time;
    chk("out_valid_timeout", out_valid, 1'b1);
  endtask

  task automatic release_out;
    chk("start_ready_low_in_done", start_ready, 1'b0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_after_handshake", out_valid, 1'b0);
    chk("start_ready_after_handshake", start_ready, 1'b1);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_start_ready", start_ready, 1'b1);
    chk("rst_byte_ready", byte_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_length", length, 4'd0);
    chk("rst_fields", {has_modrm, has_sib, has_disp, has_imm, disp_size, modrm, sib, err_too_long}, 64'd0);
    chk("rst_disp_imm", {disp, imm}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // RM_IMM, 32-bit, SIB + disp32 + imm32
    start_instr(ENC_RM_IMM, 1'b0, 2'd2, 4'd1);
    chk("t1_first_byte_ready", br_first, 1'b1);
    byte_q = '{8'h84, 8'h24, 8'h78, 8'h56, 8'h34, 8'h12};
    if (IMM_EN) begin
      byte_q.push_back(8'hEF); byte_q.push_back(8'hBE);
      byte_q.push_back(8'hAD); byte_q.push_back(8'hDE);
    end
    feed(0);
    wait_out();
    chk("t1_has_sib", has_sib, 1'b1);
    chk("t1_modrm_sib", {modrm, sib}, 16'h8424);
    chk("t1_disp_size", disp_size, 3'd4);
    chk("t1_disp", disp, 32'h12345678);
    chk("t1_has_imm", has_imm, IMM_EN);
    chk("t1_imm", imm, IMM_EN ? 32'hDEADBEEF : 32'h0);
    chk("t1_length", length, IMM_EN ? 4'd11 : 4'd7);
    chk("t1_err", err_too_long, 1'b0);
    release_out();

    // REG_RM, 16-bit, mod=01 disp8
    start_instr(ENC_REG_RM, 1'b1, 2'd0, 4'd1);
    byte_q = '{8'h46, 8'hF0};
    feed(0);
    wait_out();
    chk("t2_latency", out_t - start_t, 64'd20);
    chk("t2_has_sib", has_sib, 1'b0);
    chk("t2_disp_size", disp_size, 3'd1);
    chk("t2_disp", disp, 32'hFFFFFFF0);
    chk("t2_length", length, 4'd3);
    release_out();

    // REG_RM, 16-bit, mod=00 rm=110 disp16
    start_instr(ENC_REG_RM, 1'b1, 2'd0, 4'd2);
    byte_q = '{8'h06, 8'h34, 8'h82};
    feed(0);
    wait_out();
    chk("t3_disp_size", disp_size, 3'd2);
    chk("t3_disp", disp, 32'hFFFF8234);
    chk("t3_has_disp", has_disp, 1'b1);
    chk("t3_length", length, 4'd5);
    release_out();

    // SIB base=101 with mod=00 forces disp32
    start_instr(ENC_RM, 1'b0, 2'd0, 4'd1);
    byte_q = '{8'h04, 8'h25, 8'h00, 8'h10, 8'h00, 8'h00};
    feed(0);
    wait_out();
    chk("t4_has_sib", has_sib, 1'b1);
    chk("t4_disp_size", disp_size, 3'd4);
    chk("t4_disp", disp, 32'h00001000);
    chk("t4_length", length, 4'd7);
    release_out();

    // Register-direct ModR/M only
    start_instr(ENC_RM_REG, 1'b0, 2'd0, 4'd3);
    byte_q = '{8'hC3};
    feed(0);
    wait_out();
    chk("t5_latency", out_t - start_t, 64'd10);
    chk("t5_flags", {has_modrm, has_sib, has_disp}, 3'b100);
    chk("t5_modrm", modrm, 8'hC3);
    chk("t5_length", length, 4'd4);
    release_out();

    // Length exactly at the limit: no error
    start_instr(ENC_RM, 1'b0, 2'd0, 4'd10);
    byte_q = '{8'h05, 8'h11, 8'h22, 8'h33, 8'h44};
    feed(0);
    wait_out();
    chk("t6_err", err_too_long, 1'b0);
    chk("t6_disp", disp, 32'h44332211);
    chk("t6_length", length, 4'd15);
    release_out();

    // Length limit hit mid-displacement
    start_instr(ENC_RM, 1'b0, 2'd0, 4'd12);
    byte_q = '{8'h05, 8'h11, 8'h22, 8'h33, 8'h44};
    feed(0);
    wait_out();
    chk("t7_err", err_too_long, 1'b1);
    chk("t7_length", length, 4'd15);
    chk("t7_partial_disp", disp, 32'h00002211);
    chk("t7_byte_ready", byte_ready, 1'b0);
    release_out();

    // Limit reached before ModR/M: no byte ever requested
    start_instr(ENC_RM, 1'b0, 2'd0, 4'd15);
    chk("t8_byte_ready", br_first, 1'b0);
    wait_out();
    chk("t8_err", err_too_long, 1'b1);
    chk("t8_has_modrm", has_modrm, 1'b0);
    chk("t8_length", length, 4'd15);
    release_out();

    // byte_valid every other cycle, then out_ready held low for 3 cycles
    start_instr(ENC_REG_RM, 1'b0, 2'd0, 4'd2);
    byte_q = '{8'h80, 8'h04, 8'h03, 8'h02, 8'h01};
    feed(1);
    wait_out();
    for (int i = 0; i < 3; i++) begin
      chk("t9_hold_valid", out_valid, 1'b1);
      chk("t9_hold_disp", disp, 32'h01020304);
      chk("t9_hold_length", length, 4'd7);
      @(posedge clk); #1;
    end
    release_out();

    // Reset pulsed mid-DISP
    start_instr(ENC_DISP32, 1'b0, 2'd0, 4'd1);
    byte_q = '{8'h11, 8'h22};
    feed(0);
    chk("t10_mid_disp_byte_ready", byte_ready, 1'b1);
    rst = 1'b1;
    #1;
    chk("t10_rst_start_ready", start_ready, 1'b1);
    chk("t10_rst_out_valid", out_valid, 1'b0);
    chk("t10_rst_byte_ready", byte_ready, 1'b0);
    chk("t10_rst_record", {disp, length, has_disp}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("t10_no_output_after_rst", out_valid, 1'b0);

    // DISP8 form after reset recovery
    start_instr(ENC_DISP8, 1'b0, 2'd0, 4'd1);
    byte_q = '{8'h80};
    feed(0);
    wait_out();
    chk("t11_has_modrm", has_modrm, 1'b0);
    chk("t11_disp_size", disp_size, 3'd1);
    chk("t11_disp", disp, 32'hFFFFFF80);
    chk("t11_length", length, 4'd2);
    release_out();

    // REG_IMM: completes immediately when immediates are not consumed
    start_instr(ENC_REG_IMM, 1'b0, 2'd0, 4'd1);
    chk("t12_byte_ready", br_first, IMM_EN);
    if (IMM_EN) byte_q.push_back(8'h7F);
    feed(0);
    wait_out();
    chk("t12_latency", out_t - start_t, IMM_EN ? 64'd10 : 64'd0);
    chk("t12_has_imm", has_imm, IMM_EN);
    chk("t12_imm", imm, IMM_EN ? 32'h7F : 32'h0);
    chk("t12_length", length, IMM_EN ? 4'd2 : 4'd1);
    release_out();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
